// File: rtl/synthesijer_fdiv32_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synthesijer_fdiv32_seq_if : operand/result handshake for the divider |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface synthesijer_fdiv32_seq_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        nd;
  logic [31:0] result;
  logic        valid;
  logic        busy;

  modport master (output a, output b, output nd, input result, input valid, input busy);
  modport slave  (input a, input b, input nd, output result, output valid, output busy);
endinterface
`default_nettype wire

// File: rtl/synthesijer_fdiv32_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synthesijer_fdiv32_seq : iterative binary32 divider, 29-cycle result |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module synthesijer_fdiv32_seq (
  input  wire logic               clk,
  input  wire logic               reset,
  synthesijer_fdiv32_seq_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    DIV    = 3'd2,
    ROUND  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [31:0] c_qnan     = 32'h7FC0_0000;
  localparam logic [4:0]  c_div_last = 5'd25;

  state_t             r_state;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [4:0]         r_cnt;
  logic [23:0]        r_mb;
  logic [25:0]        r_rem;
  logic [25:0]        r_q;
  logic signed [9:0]  r_exp;
  logic               r_sign;
  logic               r_special;
  logic [31:0]        r_special_val;
  logic [31:0]        r_result;
  logic               r_valid;
  logic               r_busy;

  // Operand decode from the captured operands
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic [23:0] w_ma, w_mb;
  logic        w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic        w_sign, w_swap;
  logic [25:0] w_rem0;
  logic [9:0]  w_exp0;
  logic        w_special;
  logic [31:0] w_special_val;

  assign w_ea     = r_a[30:23];
  assign w_eb     = r_b[30:23];
  assign w_fa     = r_a[22:0];
  assign w_fb     = r_b[22:0];
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
  assign w_sign   = r_a[31] ^ r_b[31];
  assign w_ma     = w_a_zero ? 24'd0 : {1'b1, w_fa};
  assign w_mb     = w_b_zero ? 24'd0 : {1'b1, w_fb};
  // Pre-shifting the dividend keeps the quotient in [1,2)
  assign w_swap   = (w_ma < w_mb);
  assign w_rem0   = w_swap ? {1'b0, w_ma, 1'b0} : {2'b00, w_ma};
  assign w_exp0   = {2'b00, w_ea} - {2'b00, w_eb} + 10'd127 - {9'd0, w_swap};

  always_comb begin
    w_special     = 1'b1;
    w_special_val = c_qnan;
    if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
      w_special_val = c_qnan;
    else if (w_a_inf || w_b_zero)
      w_special_val = {w_sign, 8'hFF, 23'd0};
    else if (w_b_inf || w_a_zero)
      w_special_val = {w_sign, 31'd0};
    else
      w_special = 1'b0;
  end

  // One restoring step per DIV cycle
  logic        w_ge;
  logic [25:0] w_rem_sel;
  logic [25:0] w_rem_next;

  assign w_ge       = (r_rem >= {2'b00, r_mb});
  assign w_rem_sel  = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;
  assign w_rem_next = w_rem_sel << 1;

  // Round-to-nearest-even on q = 24 significand bits, guard, round
  logic              w_guard, w_sticky, w_up, w_carry;
  logic [24:0]       w_sig;
  logic signed [9:0] w_exp_r;
  logic [31:0]       w_round_result;

  assign w_guard  = r_q[1];
  assign w_sticky = r_q[0] | (r_rem != 26'd0);
  assign w_up     = w_guard & (w_sticky | r_q[2]);
  assign w_sig    = {1'b0, r_q[25:2]} + {24'd0, w_up};
  assign w_carry  = (w_sig[24:23] == 2'b10);
  assign w_exp_r  = r_exp + {9'd0, w_carry};

  always_comb begin
    w_round_result = {r_sign, w_exp_r[7:0], w_sig[22:0]};
    if (r_special)
      w_round_result = r_special_val;
    else if (w_exp_r >= 10'sd255)
      w_round_result = {r_sign, 8'hFF, 23'd0};
    else if (w_exp_r <= 10'sd0)
      w_round_result = {r_sign, 31'd0};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_a           <= 32'd0;
      r_b           <= 32'd0;
      r_cnt         <= 5'd0;
      r_mb          <= 24'd0;
      r_rem         <= 26'd0;
      r_q           <= 26'd0;
      r_exp         <= 10'sd0;
      r_sign        <= 1'b0;
      r_special     <= 1'b0;
      r_special_val <= 32'd0;
      r_result      <= 32'd0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.nd) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_busy  <= 1'b1;
            r_state <= UNPACK;
          end
        end
        UNPACK: begin
          r_mb          <= w_mb;
          r_rem         <= w_rem0;
          r_exp         <= w_exp0;
          r_sign        <= w_sign;
          r_special     <= w_special;
          r_special_val <= w_special_val;
          r_q           <= 26'd0;
          r_cnt         <= 5'd0;
          r_state       <= DIV;
        end
        DIV: begin
          r_q   <= {r_q[24:0], w_ge};
          r_rem <= w_rem_next;
          if (r_cnt == c_div_last) begin
            r_cnt   <= 5'd0;
            r_state <= ROUND;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        ROUND: begin
          r_result <= w_round_result;
          r_valid  <= 1'b1;
          r_state  <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.valid  = r_valid;
  assign bus.busy   = r_busy;
endmodule
`default_nettype wire

// File: doc/synthesijer_fdiv32_seq.md
SYNTHESIJER_FDIV32_SEQ -- requirements
Module: synthesijer_fdiv32_seq

Interface
REQ-001 Parameters: none; the latency and number format are fixed.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset: state clears on a rising clk edge while reset=0.
REQ-004 a  input  32  dividend, IEEE-754 binary32.
REQ-005 b  input  32  divisor, IEEE-754 binary32.
REQ-006 nd  input  1  new-data strobe; a and b are sampled on the edge where nd=1 and busy=0.
REQ-007 result  output  32  quotient a/b, binary32, registered.
REQ-008 valid  output  1  one-cycle pulse; result is valid in that cycle.
REQ-009 busy  output  1  high from the cycle after acceptance through the cycle valid=1.

Function
REQ-010 Block SHALL be a non-pipelined, iterative responder on the nd/valid interface; one operation in flight at a time.
REQ-011 FSM states SHALL be IDLE, UNPACK, DIV, ROUND, DONE; transitions:
- IDLE->UNPACK on accepted nd.
- UNPACK->DIV after 1 cycle.
- DIV->ROUND after exactly 26 cycles.
- ROUND->DONE after 1 cycle.
- DONE->IDLE after 1 cycle.
REQ-012 valid SHALL be 1 only in DONE: exactly 29 cycles after the accepting edge, for every operand class including specials.
REQ-013 nd asserted while busy=1 SHALL be ignored: no queueing, no effect on the operation in flight.
REQ-014 nd in the DONE cycle SHALL be ignored; nd in the first IDLE cycle after DONE SHALL be accepted.
REQ-015 result SHALL hold its last value until the next DONE; it changes only on entry to DONE.
REQ-016 Unpack: exponent field 0 SHALL be treated as zero (denormal inputs flushed); mantissas extended to 24 bits with the hidden 1.
REQ-017 Normalisation: if ma<mb, ma SHALL be shifted left 1 and the exponent decremented, so the quotient lies in [1,2).
REQ-018 Result exponent SHALL be ea-eb+127 minus the REQ-017 adjust, held as 10-bit signed.
REQ-019 DIV SHALL run a restoring division producing 1 quotient bit per cycle: 24 significand bits, then guard, then round bit.
REQ-020 Sticky SHALL be OR of guard-round tail and (final remainder != 0).
REQ-021 ROUND SHALL apply round-to-nearest-even.
REQ-022 If rounding carries the significand to 2.0, the significand SHALL become 1.0 and the exponent SHALL be incremented.
REQ-023 Exponent >=255 after rounding SHALL give signed infinity.
REQ-024 Exponent <=0 SHALL give signed zero: no denormal outputs, no gradual underflow.
REQ-025 Sign SHALL be sign(a) XOR sign(b) for all non-NaN results.
REQ-026 Specials, decided in UNPACK, still delivered at cycle 29:
- any NaN input, 0/0, or inf/inf -> 0x7FC00000;
- finite nonzero/0 -> signed inf;
- inf/finite -> signed inf;
- finite/inf -> signed zero;
- 0/nonzero-finite -> signed zero.

Reset
REQ-027 On reset=0 at a clk edge: state=IDLE, result=0x00000000, valid=0, busy=0, iteration counter=0.
REQ-028 Reset mid-operation SHALL abort the operation: no valid pulse for it, and the next accepted nd completes normally.
REQ-029 nd sampled in the same cycle as reset=0 SHALL be discarded.

Verification
REQ-030 a=0x40C00000, b=0x40000000, nd pulse -> valid exactly 29 cycles later, result=0x40400000; busy high for cycles 1..29.
REQ-031 a=0x3F800000, b=0x40400000 -> result=0x3EAAAAAB, exercising round-up.
REQ-032 Specials, each 29 cycles:
- 0x3F800000/0x00000000 -> 0x7F800000;
- 0x80000000/0x00000000 -> 0x7FC00000;
- 0x7F800000/0x7F800000 -> 0x7FC00000;
- 0xBF800000/0x7F800000 -> 0x80000000.
REQ-033 Range limits:
- 0x7F7FFFFF/0x00800000 -> 0x7F800000 (overflow);
- 0x00800000/0x7F7FFFFF -> 0x00000000 (underflow flush);
- 0x00000001/0x3F800000 -> 0x00000000 (denormal input).
REQ-034 Accept 6.0/2.0; pulse nd at cycles 5 and 29 with other operands -> single valid, result=0x40400000; nd at cycle 30 accepted.
REQ-035 Accept an operation; drive reset=0 at cycle 10 for one cycle -> no valid; all outputs equal REQ-027 values; a following 1.0/3.0 completes correctly.
